pipe_skid_buffer: RTL and testbench
===================================

Name: pipe_skid_buffer

Overview:
- Parametrised inter-stage pipeline buffer: generalises the single-entry ID/EX register to any payload width and any stage index in the stall vector.
- Adds a DEPTH-entry skid queue, so upstream can keep issuing while downstream is stalled, until the queue is full.
- Adds a valid/ready handshake, a synchronous flush, and an occupancy count.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_WIDTH, 64, payload width: operator, category, operands, write address and write enable packed together.
- STALL_WIDTH, 6, width of the pipeline stall vector.
- STAGE, 2, index of the upstream stage in the stall vector. stall[STAGE+1] is the downstream stage. Legal range 0..STALL_WIDTH-2.
- DEPTH, 2, number of queue entries. Power of two, at least 1.
- NOP_VALUE, 0, payload driven on out_data when the queue is empty (bubble).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- stall  input  STALL_WIDTH  pipeline stall vector; bit set = that stage is stalled.
- flush  input  1  synchronous discard of all queued entries.
- in_valid  input  1  upstream presents a payload.
- in_data  input  DATA_WIDTH  upstream payload.
- in_ready  output  1  queue can accept a payload this cycle.
- out_valid  output  1  head entry is valid.
- out_data  output  DATA_WIDTH  head payload, or NOP_VALUE when empty.
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset low, asynchronous):
  - count=0 and read/write pointers =0.
  - out_valid=0, out_data=NOP_VALUE, in_ready=1.
  - Queue contents are don't-care.
  - Reset mid-operation drops all entries immediately; no partial state survives.
- Definitions:
  - push = in_valid & in_ready & ~stall[STAGE] & ~flush.
  - pop = out_valid & ~stall[STAGE+1] & ~flush.
- Signal derivation:
  - in_ready = (count < DEPTH). Derived from registered count only; no combinational path from stall or pop.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when count != 0, else NOP_VALUE. Driven purely from registers.
- Each rising edge, when reset is high:
  - flush: count<=0 and pointers<=0. Overrides push and pop in the same cycle.
  - push only: mem[wr_ptr]<=in_data, wr_ptr++, count++.
  - pop only: rd_ptr++, count--.
  - push and pop together: write and read both happen and count is unchanged. Legal only while count < DEPTH, which in_ready already guarantees.
  - neither: all state held.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. With DEPTH=1 the pointers are constant 0.
- Latency:
  - A payload pushed at edge N into an empty queue appears on out_data/out_valid after edge N (1 cycle, same as the legacy buffer).
  - A payload pushed behind k queued entries appears after k further pops.
- Legacy equivalence (DEPTH=1, in_valid tied 1, downstream always ready when unstalled):
  - stall[STAGE]=1, stall[STAGE+1]=0: no push; the head pops. The queue empties and out_data=NOP_VALUE, i.e. a bubble.
  - stall[STAGE]=1, stall[STAGE+1]=1: the head is held.
  - Neither stalled: pass-through.
- Full:
  - in_ready=0 and in_data is ignored even when in_valid=1.
  - Upstream must extend its own stall.
- Empty and stall[STAGE+1]=0: out shows NOP_VALUE, out_valid=0; pop is inhibited.
- Queue entries are never overwritten while valid; pop while empty is impossible by construction.

Test Plan:
- Hold reset low for 3 cycles with in_valid=1, in_data=0xAA: count=0, out_valid=0, out_data=0, in_ready=1 throughout. Deassert reset: 0xAA appears on out_data one edge later.
- Pass-through, DEPTH=2, stall=0: push 0x11, 0x22, 0x33 on consecutive edges. out_data shows 0x11, 0x22, 0x33 one edge after each push; count stays 1.
- Downstream stall: stall[3]=1, stall[2]=0, push 0x01, 0x02, 0x03:
  - count reaches 2, in_ready=0, 0x03 is not accepted, out_data holds 0x01.
  - Release stall[3]: out_data shows 0x01, then 0x02, then NOP (0).
- Bubble: stall[2]=1, stall[3]=0, queue holding 0x5A: after one edge out_valid=0, out_data=0, count=0.
- Flush while full (0x01, 0x02 queued), with in_valid=1 and in_data=0x77 on the same edge: count=0 and out_valid=0 after the edge. 0x77 is discarded.
- Wrap-around, DEPTH=4: run 10 push/pop pairs with values 0..9 under random downstream stalls. The output order is exactly 0..9 and count never exceeds 4.

Source files
------------

// File: rtl/pipe_skid_buffer.sv
// Inter-stage pipeline buffer with a DEPTH-entry skid queue.
// Valid/ready handshake, synchronous flush and occupancy count.
module pipe_skid_buffer #(
  parameter int DATA_WIDTH  = 64,
  parameter int STALL_WIDTH = 6,
  parameter int STAGE       = 2,
  parameter int DEPTH       = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [STALL_WIDTH-1:0]     stall,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (STAGE < 0 || STAGE > STALL_WIDTH - 2) begin : g_bad_stage
    $error("pipe_skid_buffer: STAGE out of range");
  end
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pipe_skid_buffer: DEPTH must be a power of two");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  push;
  logic                  pop;

  // With a single entry the pointers never move.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    return p + PW'(1);
  endfunction

  assign in_ready  = (cnt < FULL);
  assign out_valid = (cnt != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : NOP_VALUE;
  assign count     = cnt;

  assign push = in_valid & in_ready & ~stall[STAGE] & ~flush;
  assign pop  = out_valid & ~stall[STAGE+1] & ~flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; empty entries are masked by cnt.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer.
// Vector table on a DEPTH=2 instance, random model run on DEPTH=4.
module tb_pipe_skid_buffer;

  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [5:0]    stall_a, stall_b;
  logic          flush_a, flush_b;
  logic          iv_a, iv_b;
  logic [DW-1:0] id_a, id_b;
  logic          ir_a, ir_b;
  logic          ov_a, ov_b;
  logic [DW-1:0] od_a, od_b;
  logic [1:0]    cnt_a;
  logic [2:0]    cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  pipe_skid_buffer #(
    .DATA_WIDTH(DW), .STALL_WIDTH(6), .STAGE(2),
    .DEPTH(2), .NOP_VALUE(8'h00)
  ) dut_a (
    .clock(clock), .reset(reset), .stall(stall_a),
    .flush(flush_a), .in_valid(iv_a), .in_data(id_a),
    .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a),
    .count(cnt_a)
  );

  pipe_skid_buffer #(
    .DATA_WIDTH(DW), .STALL_WIDTH(6), .STAGE(2),
    .DEPTH(4), .NOP_VALUE(8'h00)
  ) dut_b (
    .clock(clock), .reset(reset), .stall(stall_b),
    .flush(flush_b), .in_valid(iv_b), .in_data(id_b),
    .in_ready(ir_b), .out_valid(ov_b), .out_data(od_b),
    .count(cnt_b)
  );

  typedef struct {
    logic [5:0]    stall;
    logic          flush;
    logic          iv;
    logic [DW-1:0] d;
    logic [1:0]    cnt;
    logic          ov;
    logic [DW-1:0] od;
    logic          rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic [5:0] s, logic f, logic v, logic [DW-1:0] d,
    logic [1:0] c, logic o, logic [DW-1:0] od, logic r);
    vec_t t;
    t.stall = s; t.flush = f; t.iv = v; t.d = d;
    t.cnt = c; t.ov = o; t.od = od; t.rdy = r;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_a(string tag, logic [1:0] c, logic o,
                         logic [DW-1:0] d, logic r);
    check({tag, ".count"}, 32'(cnt_a), 32'(c));
    check({tag, ".out_valid"}, 32'(ov_a), 32'(o));
    check({tag, ".out_data"}, 32'(od_a), 32'(d));
    check({tag, ".in_ready"}, 32'(ir_a), 32'(r));
  endtask

  // Reference model for dut_b: a plain queue.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] got[$];

  task automatic model_check(string tag);
    logic [DW-1:0] eh;
    eh = (mq.size() != 0) ? mq[0] : 8'h00;
    check({tag, ".count"}, 32'(cnt_b), 32'(mq.size()));
    check({tag, ".out_valid"}, 32'(ov_b), 32'(mq.size() != 0));
    check({tag, ".out_data"}, 32'(od_b), 32'(eh));
    check({tag, ".in_ready"}, 32'(ir_b), 32'(mq.size() < 4));
  endtask

  // Decide this cycle's transfer from the model, then clock it.
  task automatic model_step(input bit record);
    bit do_push, do_pop;
    do_push = iv_b && (mq.size() < 4) && !stall_b[2] && !flush_b;
    do_pop  = (mq.size() != 0) && !stall_b[3] && !flush_b;
    if (record && do_pop) got.push_back(od_b);
    tick();
    if (flush_b) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(id_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    stall_a = '0; flush_a = 1'b0; iv_a = 1'b1; id_a = 8'hAA;
    stall_b = '0; flush_b = 1'b0; iv_b = 1'b0; id_b = 8'h00;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_a($sformatf("reset%0d", i), 2'd0, 1'b0, 8'h00, 1'b1);
      check("reset.b_count", 32'(cnt_b), 32'd0);
    end
    reset = 1'b1;
    tick();
    check_a("reset_release", 2'd1, 1'b1, 8'hAA, 1'b1);

    tbl.push_back(mk(6'h00, 0, 1, 8'h11, 1, 1, 8'h11, 1));
    tbl.push_back(mk(6'h00, 0, 1, 8'h22, 1, 1, 8'h22, 1));
    tbl.push_back(mk(6'h00, 0, 1, 8'h33, 1, 1, 8'h33, 1));
    tbl.push_back(mk(6'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1));
    tbl.push_back(mk(6'h08, 0, 1, 8'h01, 1, 1, 8'h01, 1));
    tbl.push_back(mk(6'h08, 0, 1, 8'h02, 2, 1, 8'h01, 0));
    tbl.push_back(mk(6'h08, 0, 1, 8'h03, 2, 1, 8'h01, 0));
    tbl.push_back(mk(6'h00, 0, 0, 8'h00, 1, 1, 8'h02, 1));
    tbl.push_back(mk(6'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1));
    tbl.push_back(mk(6'h00, 0, 1, 8'h5A, 1, 1, 8'h5A, 1));
    tbl.push_back(mk(6'h04, 0, 1, 8'h66, 0, 0, 8'h00, 1));
    tbl.push_back(mk(6'h08, 0, 1, 8'h01, 1, 1, 8'h01, 1));
    tbl.push_back(mk(6'h08, 0, 1, 8'h02, 2, 1, 8'h01, 0));
    tbl.push_back(mk(6'h00, 1, 1, 8'h77, 0, 0, 8'h00, 1));
    tbl.push_back(mk(6'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1));
    tbl.push_back(mk(6'h00, 0, 1, 8'hAB, 1, 1, 8'hAB, 1));
    tbl.push_back(mk(6'h0C, 0, 1, 8'hCD, 1, 1, 8'hAB, 1));
    tbl.push_back(mk(6'h08, 0, 1, 8'hEE, 2, 1, 8'hAB, 0));
    tbl.push_back(mk(6'h00, 0, 0, 8'h00, 1, 1, 8'hEE, 1));
    tbl.push_back(mk(6'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1));

    foreach (tbl[i]) begin
      stall_a = tbl[i].stall;
      flush_a = tbl[i].flush;
      iv_a    = tbl[i].iv;
      id_a    = tbl[i].d;
      tick();
      check_a($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ov,
              tbl[i].od, tbl[i].rdy);
    end

    // Asynchronous reset in the middle of a cycle with a full queue.
    stall_a = 6'h08; iv_a = 1'b1; id_a = 8'hA1;
    tick();
    id_a = 8'hA2;
    tick();
    check_a("prefill", 2'd2, 1'b1, 8'hA1, 1'b0);
    iv_a = 1'b0; stall_a = '0;
    #2 reset = 1'b0;
    #1 check_a("async_reset", 2'd0, 1'b0, 8'h00, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    check_a("post_reset", 2'd0, 1'b0, 8'h00, 1'b1);

    // Wrap-around on DEPTH=4: values 0..9 under random stalls.
    begin
      int nv;
      nv = 0;
      mq.delete();
      got.delete();
      for (int c = 0; c < 400 && got.size() < 10; c++) begin
        iv_b    = (nv < 10);
        id_b    = 8'(nv);
        stall_b = '0;
        stall_b[3] = ($urandom_range(0, 2) == 0);
        if (iv_b && mq.size() < 4) nv++;
        model_step(1'b1);
        model_check("wrap");
        if (cnt_b > 3'd4) check("wrap.count_max", 32'(cnt_b), 32'd4);
      end
      check("wrap.popped", 32'(got.size()), 32'd10);
      foreach (got[i]) check($sformatf("wrap.order%0d", i),
                             32'(got[i]), 32'(i));
    end

    // Random traffic with both stalls and occasional flushes.
    for (int c = 0; c < 300; c++) begin
      iv_b    = 1'($urandom_range(0, 1));
      id_b    = 8'($urandom);
      stall_b = 6'($urandom);
      flush_b = ($urandom_range(0, 15) == 0);
      model_step(1'b0);
      model_check($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
